// File: rtl/pc.sv
// pc: dual-issue fetch program counter with stall hold, branch redirect and async active-low reset.
module pc (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_is_taken,
    input  logic [63:0] fu_target_pc,
    input  logic [63:0] Imem2proc_data,
    input  logic        rs_stall,
    input  logic        rob_stall,
    input  logic        memory_structure_hazard_stall,
    input  logic        pc_enable,
    output logic [63:0] proc2Imem_addr,
    output logic [63:0] next_PC_out,
    output logic [31:0] inst1_out,
    output logic [31:0] inst2_out,
    output logic        inst1_is_valid,
    output logic        inst2_is_valid
);
    localparam logic [31:0] NOP = 32'h47FF041F;
    logic [63:0] pc_q, pc_d;
    logic        stall, fetch;
    always_comb begin
        stall          = rs_stall | rob_stall | memory_structure_hazard_stall | ~pc_enable;
        fetch          = reset & ~stall & ~branch_is_taken;
        proc2Imem_addr = {pc_q[63:3], 3'b000};
        // A held or resetting fetch consumes nothing, so the successor is the PC itself.
        next_PC_out    = !reset ? 64'd0 : stall ? pc_q : pc_q + (pc_q[2] ? 64'd4 : 64'd8);
        inst1_is_valid = fetch;
        inst2_is_valid = fetch & ~pc_q[2];
        inst1_out      = fetch ? (pc_q[2] ? Imem2proc_data[63:32] : Imem2proc_data[31:0]) : NOP;
        inst2_out      = inst2_is_valid ? Imem2proc_data[63:32] : NOP;
        pc_d           = branch_is_taken ? {fu_target_pc[63:2], 2'b00} : next_PC_out;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) pc_q <= 64'd0;
        else        pc_q <= pc_d;
endmodule

// File: tb/tb_pc.sv
// tb_pc: directed-vector bench for the fetch PC.
module tb_pc;
    localparam logic [31:0] NOP = 32'h47FF041F;
    logic        clock = 1'b0;
    logic        reset, branch_is_taken, rs_stall, rob_stall, memory_structure_hazard_stall, pc_enable;
    logic [63:0] fu_target_pc, Imem2proc_data, proc2Imem_addr, next_PC_out;
    logic [31:0] inst1_out, inst2_out;
    logic        inst1_is_valid, inst2_is_valid;
    int          total = 0, bad = 0;
    logic [63:0] held;

    pc dut (
        .clock(clock), .reset(reset), .branch_is_taken(branch_is_taken),
        .fu_target_pc(fu_target_pc), .Imem2proc_data(Imem2proc_data),
        .rs_stall(rs_stall), .rob_stall(rob_stall),
        .memory_structure_hazard_stall(memory_structure_hazard_stall), .pc_enable(pc_enable),
        .proc2Imem_addr(proc2Imem_addr), .next_PC_out(next_PC_out),
        .inst1_out(inst1_out), .inst2_out(inst2_out),
        .inst1_is_valid(inst1_is_valid), .inst2_is_valid(inst2_is_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_stall(input int k, input logic on);
        rs_stall                      = (k == 0) ? on : 1'b0;
        rob_stall                     = (k == 1) ? on : 1'b0;
        memory_structure_hazard_stall = (k == 2) ? on : 1'b0;
        pc_enable                     = (k == 3) ? ~on : 1'b1;
    endtask

    initial begin
        reset = 1'b0; branch_is_taken = 1'b0; fu_target_pc = '0;
        rs_stall = 1'b0; rob_stall = 1'b0; memory_structure_hazard_stall = 1'b0; pc_enable = 1'b1;
        Imem2proc_data = 64'h1234_4567_5678_3456;
        #3;
        chk("rst_addr", proc2Imem_addr, 64'd0);
        chk("rst_next", next_PC_out, 64'd0);
        chk("rst_v1", inst1_is_valid, 0);
        chk("rst_v2", inst2_is_valid, 0);
        chk("rst_i1", inst1_out, NOP);
        chk("rst_i2", inst2_out, NOP);

        @(negedge clock); reset = 1'b1; #1;
        chk("f0_addr", proc2Imem_addr, 64'd0);
        chk("f0_i1", inst1_out, 32'h5678_3456);
        chk("f0_i2", inst2_out, 32'h1234_4567);
        chk("f0_v1", inst1_is_valid, 1);
        chk("f0_v2", inst2_is_valid, 1);
        chk("f0_next", next_PC_out, 64'd8);
        @(negedge clock); #1;
        chk("f1_addr", proc2Imem_addr, 64'd8);
        chk("f1_next", next_PC_out, 64'd16);
        @(negedge clock); #1;
        chk("f2_addr", proc2Imem_addr, 64'd16);
        chk("f2_next", next_PC_out, 64'd24);

        branch_is_taken = 1'b1; fu_target_pc = 64'h100; #1;
        chk("br_v1", inst1_is_valid, 0);
        chk("br_v2", inst2_is_valid, 0);
        chk("br_i1", inst1_out, NOP);
        @(negedge clock); branch_is_taken = 1'b0; #1;
        chk("br_addr", proc2Imem_addr, 64'h100);
        chk("br_next", next_PC_out, 64'h108);

        branch_is_taken = 1'b1; fu_target_pc = 64'h104;
        @(negedge clock); branch_is_taken = 1'b0; Imem2proc_data = 64'h0000_0010_9008_1406; #1;
        chk("half_addr", proc2Imem_addr, 64'h100);
        chk("half_i1", inst1_out, 32'h0000_0010);
        chk("half_v1", inst1_is_valid, 1);
        chk("half_i2", inst2_out, NOP);
        chk("half_v2", inst2_is_valid, 0);
        chk("half_next", next_PC_out, 64'h108);
        @(negedge clock); #1;
        chk("realign_addr", proc2Imem_addr, 64'h108);
        chk("realign_v2", inst2_is_valid, 1);
        chk("realign_next", next_PC_out, 64'h110);

        held = 64'h108;
        for (int k = 0; k < 4; k++) begin
            set_stall(k, 1'b1); #1;
            chk($sformatf("st%0d_v1", k), inst1_is_valid, 0);
            chk($sformatf("st%0d_v2", k), inst2_is_valid, 0);
            chk($sformatf("st%0d_i1", k), inst1_out, NOP);
            chk($sformatf("st%0d_i2", k), inst2_out, NOP);
            chk($sformatf("st%0d_addr", k), proc2Imem_addr, held);
            @(negedge clock); #1;
            chk($sformatf("st%0d_hold", k), proc2Imem_addr, held);
            set_stall(k, 1'b0); #1;
            chk($sformatf("st%0d_rel_v1", k), inst1_is_valid, 1);
            chk($sformatf("st%0d_rel_addr", k), proc2Imem_addr, held);
            @(negedge clock); #1;
            held = held + 64'd8;
            chk($sformatf("st%0d_adv", k), proc2Imem_addr, held);
        end

        rob_stall = 1'b1; branch_is_taken = 1'b1; fu_target_pc = 64'h203;
        @(negedge clock); rob_stall = 1'b0; branch_is_taken = 1'b0; #1;
        chk("brst_addr", proc2Imem_addr, 64'h200);

        branch_is_taken = 1'b1; fu_target_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        @(negedge clock); branch_is_taken = 1'b0; #1;
        chk("wrap_addr", proc2Imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_next", next_PC_out, 64'd0);
        @(negedge clock); #1;
        chk("wrap_after", proc2Imem_addr, 64'd0);
        @(negedge clock); #1;
        chk("pre_arst", proc2Imem_addr, 64'd8);

        @(posedge clock); #2; reset = 1'b0; #1;
        chk("arst_addr", proc2Imem_addr, 64'd0);
        chk("arst_next", next_PC_out, 64'd0);
        chk("arst_v1", inst1_is_valid, 0);
        chk("arst_v2", inst2_is_valid, 0);
        chk("arst_i1", inst1_out, NOP);
        chk("arst_i2", inst2_out, NOP);
        @(negedge clock); reset = 1'b1; #1;
        chk("resume_addr", proc2Imem_addr, 64'd0);
        chk("resume_v1", inst1_is_valid, 1);
        chk("resume_next", next_PC_out, 64'd8);
        @(negedge clock); #1;
        chk("resume_step", proc2Imem_addr, 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
